t_ff_sr_decoder: RTL

Converts a stream of T (toggle) requests into the equivalent stream of S/R commands, the inverse of our SR-from-T excitation path. It keeps a shadow copy of the flip-flop state, turns each toggle into a set or reset depending on that state, and buffers the commands in a small FIFO with valid/ready handshakes on both sides. It sits between a toggle-producing controller and any downstream SR-style flip-flop or latch bank.

---
 rtl/t_ff_sr_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/t_ff_sr_decoder.sv
// rtl/t_ff_sr_decoder.sv - toggle-request to set/reset command converter with command FIFO
//
// Purpose:
//   Keeps a shadow copy of a T flip-flop's state and turns each accepted toggle
//   request into the equivalent S or R command. Commands are buffered in a
//   DEPTH-entry FIFO with valid/ready handshakes on the input and output sides.
//
// Configuration macro:
//   SR_EVENT_CNT_EN - when defined, adds the set_cnt / rst_cnt ports and their
//                     saturating pop counters. When undefined, they are absent.
//
// Parameters:
//   DEPTH     - command FIFO entries (power of two, >= 2)
//   CNT_W     - event counter width (used only with SR_EVENT_CNT_EN)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   t         - toggle request bit of the input beat
//   t_valid   - input beat present
//   t_ready   - beat can be accepted (== !full)
//   s         - set command at FIFO head (0 when cmd_valid=0)
//   r         - reset command at FIFO head (0 when cmd_valid=0)
//   cmd_valid - FIFO non-empty
//   cmd_ready - downstream consumes the head command
//   q         - shadow state after all accepted toggles
//   qbar      - ~q
//   full      - FIFO holds DEPTH commands
//   set_cnt   - S commands popped, saturating (SR_EVENT_CNT_EN only)
//   rst_cnt   - R commands popped, saturating (SR_EVENT_CNT_EN only)

module t_ff_sr_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             t_valid,
  output logic             t_ready,
  output logic             s,
  output logic             r,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             q,
  output logic             qbar,
  output logic             full
`ifdef SR_EVENT_CNT_EN
  ,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Elaboration-time sanity checks on the parameters.
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  // One bit per entry: 1 = S command, 0 = R command.
  logic [DEPTH-1:0] mem;
  logic             q_reg;

  logic             empty;
  logic             head;
  logic             accept;
  logic             push;
  logic             pop;

  // Status is derived only from registered pointers and storage, so no
  // combinational path exists from t_valid or cmd_ready to any output.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign cmd_valid = !empty;
  assign t_ready   = !full;
  assign s         = cmd_valid & head;
  assign r         = cmd_valid & ~head;
  assign q         = q_reg;
  assign qbar      = ~q_reg;

  // A pop in the same cycle as full does not open t_ready; the freed slot is
  // only offered once the read pointer has moved.
  assign accept = t_valid & t_ready;
  assign push   = accept & t;
  assign pop    = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
      q_reg  <= 1'b0;
    end else begin
      if (push) begin
        // Toggling from 0 needs a set; toggling from 1 needs a reset.
        mem[wr_ptr[AW-1:0]] <= ~q_reg;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
        q_reg               <= ~q_reg;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

`ifdef SR_EVENT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt <= '0;
      rst_cnt <= '0;
    end else if (pop) begin
      if (head && (set_cnt != CNT_MAX)) begin
        set_cnt <= set_cnt + CNT_W'(1);
      end
      if (!head && (rst_cnt != CNT_MAX)) begin
        rst_cnt <= rst_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
